// File: rtl/br_pkg.sv
// Shared definitions for branch resolution and prediction.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   f3_e      branch condition encodings (funct3)
//   SNT..ST   2-bit saturating counter encodings
//   bht_idx   word-aligned PC -> BHT index (low idx_w bits of pc[..:2])
package br_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } f3_e;

  localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  // PCs are word aligned, so bits [1:0] carry no information for indexing.
  function automatic int unsigned bht_idx(input logic [63:0] pc, input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: funct3 + ALU flags of (rs1 - rs2) -> cond.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   funct3  in  3  branch condition select
//   z,n,v,c in  1  zero / negative / overflow / carry-out of rs1 + ~rs2 + 1
//   cond    out 1  branch condition holds
module br_cond_eval
  import br_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  input  logic       c,
  output logic       cond
);

  // Carry-out of the subtraction is set when rs1 >= rs2 unsigned, so BLTU
  // is ~C and BGEU is C. Encodings 010/011 are not branches and never hold.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = z;
      F3_BNE:  cond = ~z;
      F3_BLT:  cond = n ^ v;
      F3_BGE:  cond = ~(n ^ v);
      F3_BLTU: cond = ~c;
      F3_BGEU: cond = c;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a PC-indexed 2-bit BHT for fetch prediction.
// Latency: redirect registered, valid 1 cycle after EX; prediction combinational.
// Backpressure: none; one EX instruction accepted every cycle.
//
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   if_pc / if_pred_taken      fetch lookup: MSB of BHT[idx(if_pc)]
//   ex_*                       EX instruction: type, condition, flags, targets
//   redirect_valid/redirect_pc registered flush + new fetch PC
//   br_count / mispred_count   saturating conditional-branch statistics
module branch_predict_unit
  import br_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = 2'b01,
  parameter int         CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic             ex_ui,
  input  logic             ex_u_control,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_z,
  input  logic             ex_n,
  input  logic             ex_v,
  input  logic             ex_c,
  input  logic [XLEN-1:0]  ex_pcimm,
  input  logic [XLEN-1:0]  ex_aluout,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;

  logic             cond;
  logic             is_jalr;
  logic             is_jal;
  logic             is_upc;
  logic             is_br;
  logic             taken;
  logic             mispred;
  logic             do_redirect;
  logic             br_upd;
  logic [XLEN-1:0]  target;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;
  logic             alu_lsb_unused;

  // The JALR target always has its LSB cleared.
  assign alu_lsb_unused = ex_aluout[0];

  assign if_idx = IDX_W'(bht_idx(64'(if_pc), IDX_W));
  assign ex_idx = IDX_W'(bht_idx(64'(ex_pc), IDX_W));

  // Combinational read of the pre-edge array content gives read-before-write
  // when fetch and EX hit the same entry in one cycle.
  assign if_pred_taken = bht[if_idx][1];

  br_cond_eval u_cond (
    .funct3 (ex_funct3),
    .z      (ex_z),
    .n      (ex_n),
    .v      (ex_v),
    .c      (ex_c),
    .cond   (cond)
  );

  // Type decode with priority jalr > jal > ui > branch, so an illegal
  // multi-hot combination still resolves as exactly one instruction kind.
  assign is_jalr = ex_jalr;
  assign is_jal  = ex_jal & ~ex_jalr;
  assign is_upc  = ex_ui & ~ex_u_control & ~ex_jal & ~ex_jalr;
  assign is_br   = ex_branch & ~ex_ui & ~ex_jal & ~ex_jalr;

  assign taken   = is_jalr | is_jal | is_upc | (is_br & cond);
  assign target  = is_jalr ? {ex_aluout[XLEN-1:1], 1'b0}
                 : (taken ? ex_pcimm : ex_pc + XLEN'(4));

  assign mispred     = is_br & (cond != ex_pred_taken);
  assign do_redirect = ex_valid & (is_jalr | is_jal | is_upc | mispred);
  assign br_upd      = ex_valid & is_br;

  // Saturating 2-bit counter step toward the resolved direction.
  always_comb begin
    ctr_cur = bht[ex_idx];
    ctr_nxt = ctr_cur;
    if (cond) begin
      if (ctr_cur != ST) ctr_nxt = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != SNT) ctr_nxt = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else if (br_upd) begin
      bht[ex_idx] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= do_redirect;
      if (do_redirect) redirect_pc <= target;
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (br_upd) begin
      if (br_count != '1) br_count <= br_count + CNT_W'(1);
      if (mispred && (mispred_count != '1)) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic        ex_ui;
  logic        ex_u_control;
  logic [2:0]  ex_funct3;
  logic        ex_z;
  logic        ex_n;
  logic        ex_v;
  logic        ex_c;
  logic [31:0] ex_pcimm;
  logic [31:0] ex_aluout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_predict_unit dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_pred_taken  (ex_pred_taken),
    .ex_branch      (ex_branch),
    .ex_jal         (ex_jal),
    .ex_jalr        (ex_jalr),
    .ex_ui          (ex_ui),
    .ex_u_control   (ex_u_control),
    .ex_funct3      (ex_funct3),
    .ex_z           (ex_z),
    .ex_n           (ex_n),
    .ex_v           (ex_v),
    .ex_c           (ex_c),
    .ex_pcimm       (ex_pcimm),
    .ex_aluout      (ex_aluout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: {br, jal, jalr, ui}; znvc flags packed as {z,n,v,c}.
  task automatic drive(input logic v, input logic [31:0] pc, input logic pred,
                       input logic [3:0] kind, input logic uc, input logic [2:0] f3,
                       input logic [3:0] znvc, input logic [31:0] pcimm,
                       input logic [31:0] aluout);
    ex_valid      = v;
    ex_pc         = pc;
    ex_pred_taken = pred;
    {ex_branch, ex_jal, ex_jalr, ex_ui} = kind;
    ex_u_control  = uc;
    ex_funct3     = f3;
    {ex_z, ex_n, ex_v, ex_c} = znvc;
    ex_pcimm      = pcimm;
    ex_aluout     = aluout;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 1'b0, 3'b000, 4'b0000, 32'h0, 32'h0);
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    chk(tag, if_pred_taken, exp);
  endtask

  task automatic chk_counts(input string tag, input int br, input int mis);
    chk({tag, "_br"}, br_count, 64'(br));
    chk({tag, "_mis"}, mispred_count, 64'(mis));
  endtask

  localparam logic [3:0] K_BR   = 4'b1000;
  localparam logic [3:0] K_JAL  = 4'b0100;
  localparam logic [3:0] K_JALR = 4'b0010;
  localparam logic [3:0] K_UI   = 4'b0001;

  initial begin
    reset = 1'b1;
    if_pc = 32'h100;
    idle();
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk_counts("rst", 0, 0);
    chk_pred("rst_pred", 32'h100, 1'b0);

    // 1: BEQ taken, predicted not-taken -> redirect to pcimm, counter 01->10
    drive(1, 32'h100, 0, K_BR, 0, 3'b000, 4'b1000, 32'h180, 32'h0);
    step();
    idle();
    chk("t1_rv", redirect_valid, 1'b1);
    chk("t1_rpc", redirect_pc, 32'h180);
    chk_counts("t1", 1, 1);
    chk_pred("t1_pred", 32'h100, 1'b1);

    // 2: three more taken, all predicted taken -> no redirect, counter saturates
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100, 1, K_BR, 0, 3'b000, 4'b1000, 32'h180, 32'h0);
      step();
      idle();
      chk("t2_rv", redirect_valid, 1'b0);
    end
    chk_counts("t2", 4, 1);
    chk_pred("t2_pred", 32'h100, 1'b1);

    // Saturation: 11 -> 10 keeps taken, 10 -> 01 flips to not-taken
    drive(1, 32'h100, 1, K_BR, 0, 3'b000, 4'b0000, 32'h180, 32'h0);
    step();
    idle();
    chk("sat1_rv", redirect_valid, 1'b1);
    chk("sat1_rpc", redirect_pc, 32'h104);
    chk_pred("sat1_pred", 32'h100, 1'b1);
    drive(1, 32'h100, 1, K_BR, 0, 3'b000, 4'b0000, 32'h180, 32'h0);
    step();
    idle();
    chk_pred("sat2_pred", 32'h100, 1'b0);
    chk_counts("sat", 6, 3);

    // 3: unsigned and signed compares
    drive(1, 32'h308, 0, K_BR, 0, 3'b110, 4'b0000, 32'h400, 32'h0); // BLTU C=0
    step();
    idle();
    chk("bltu_rv", redirect_valid, 1'b1);
    chk("bltu_rpc", redirect_pc, 32'h400);
    drive(1, 32'h30C, 0, K_BR, 0, 3'b111, 4'b0001, 32'h500, 32'h0); // BGEU C=1
    step();
    idle();
    chk("bgeu_rv", redirect_valid, 1'b1);
    chk("bgeu_rpc", redirect_pc, 32'h500);
    drive(1, 32'h310, 0, K_BR, 0, 3'b100, 4'b0110, 32'h600, 32'h0); // BLT N=V
    step();
    idle();
    chk("blt_rv", redirect_valid, 1'b0);
    drive(1, 32'h314, 1, K_BR, 0, 3'b010, 4'b1101, 32'h700, 32'h0); // 010 never taken
    step();
    idle();
    chk("f3010_rv", redirect_valid, 1'b1);
    chk("f3010_rpc", redirect_pc, 32'h318);
    chk_counts("t3", 10, 6);
    chk_pred("bltu_pred", 32'h308, 1'b1);

    // 4: jumps and U-type, no BHT or counter effect
    drive(1, 32'h204, 0, K_JALR, 0, 3'b000, 4'b0000, 32'h999, 32'h2003);
    step();
    idle();
    chk("jalr_rv", redirect_valid, 1'b1);
    chk("jalr_rpc", redirect_pc, 32'h2002);
    drive(1, 32'h208, 0, K_JAL, 0, 3'b000, 4'b0000, 32'h900, 32'h0);
    step();
    idle();
    chk("jal_rpc", redirect_pc, 32'h900);
    drive(1, 32'h20C, 0, K_UI, 0, 3'b000, 4'b0000, 32'h7000, 32'h0);
    step();
    idle();
    chk("ui_rpc", redirect_pc, 32'h7000);
    drive(1, 32'h210, 0, K_UI, 1, 3'b000, 4'b0000, 32'h8000, 32'h0);
    step();
    idle();
    chk("ui1_rv", redirect_valid, 1'b0);
    chk_counts("t4", 10, 6);
    chk_pred("t4_pred", 32'h204, 1'b0);

    // ex_valid=0: mispredicting BEQ ignored entirely
    drive(0, 32'h100, 0, K_BR, 0, 3'b000, 4'b1000, 32'h180, 32'h0);
    step();
    idle();
    chk("inv_rv", redirect_valid, 1'b0);
    chk_counts("inv", 10, 6);
    chk_pred("inv_pred", 32'h100, 1'b0);

    // 5: predicted-taken BNE with Z=1 at top of memory -> fall-through wraps to 0
    drive(1, 32'hFFFF_FFFC, 1, K_BR, 0, 3'b001, 4'b1000, 32'h1234, 32'h0);
    step();
    idle();
    chk("wrap_rv", redirect_valid, 1'b1);
    chk("wrap_rpc", redirect_pc, 32'h0);
    chk_counts("t5", 11, 7);

    // 6: same-index update and lookup -> old prediction before the edge
    drive(1, 32'h100, 0, K_BR, 0, 3'b000, 4'b1000, 32'h180, 32'h0);
    chk_pred("rbw_pre", 32'h100, 1'b0);
    step();
    idle();
    chk_pred("rbw_post", 32'h100, 1'b1);
    chk_counts("t6", 12, 8);

    // Reset while a redirect is pending, with a competing EX update
    drive(1, 32'h104, 1, K_BR, 0, 3'b000, 4'b0000, 32'h180, 32'h0);
    step();
    chk("pend_rv", redirect_valid, 1'b1);
    chk("pend_rpc", redirect_pc, 32'h108);
    reset = 1'b1;
    drive(1, 32'h308, 0, K_BR, 0, 3'b000, 4'b1000, 32'h400, 32'h0);
    step();
    reset = 1'b0;
    idle();
    chk("rst2_rv", redirect_valid, 1'b0);
    chk("rst2_rpc", redirect_pc, 32'h0);
    chk_counts("rst2", 0, 0);
    chk_pred("rst2_pred100", 32'h100, 1'b0);
    chk_pred("rst2_pred308", 32'h308, 1'b0);

    // Counter must restart at weakly not-taken: one taken flips it
    drive(1, 32'h100, 0, K_BR, 0, 3'b000, 4'b1000, 32'h180, 32'h0);
    step();
    idle();
    chk("post_rv", redirect_valid, 1'b1);
    chk_pred("post_pred", 32'h100, 1'b1);
    chk_counts("post", 1, 1);
    step();
    chk("post_deassert", redirect_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
